// File: rtl/reg_file_writeback_arbiter.sv
// Write-back arbiter: merges ALU results and FIFO-buffered MDU results onto the
// single register file write port, and tracks pending MDU destinations.
// Optional feature macro: REG_WB_FIFO_BYPASS_EN (MDU result skips an empty FIFO).
module reg_file_writeback_arbiter #(
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [SEL_WIDTH-1:0]      alu_sel,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      mdu_valid,
  output logic                      mdu_ready,
  input  logic [SEL_WIDTH-1:0]      mdu_sel,
  input  logic [DATA_WIDTH-1:0]     mdu_data,
  input  logic                      claim_en,
  input  logic [SEL_WIDTH-1:0]      claim_sel,
  output logic [(2**SEL_WIDTH)-1:0] pending,
  output logic [SEL_WIDTH-1:0]      write_sel,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      write_en
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t                mem [FIFO_DEPTH];
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            count;
  logic                     wr_mdu;
  logic                     push, pop, bypass, fifo_push, fifo_empty;
  logic [(2**SEL_WIDTH)-1:0] pending_nxt;

  assign mdu_ready  = count < CW'(FIFO_DEPTH);
  assign fifo_empty = (count == '0);
  assign push       = mdu_valid && mdu_ready;
  assign pop        = !alu_valid && !fifo_empty;
`ifdef REG_WB_FIFO_BYPASS_EN
  assign bypass     = push && !alu_valid && fifo_empty;
`else
  assign bypass     = 1'b0;
`endif
  assign fifo_push  = push && !bypass;

  // Storage needs no reset; occupancy is governed by count and pointers.
  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr] <= '{sel: mdu_sel, data: mdu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage; wr_mdu remembers whether the current write came from the MDU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_sel  <= '0;
      write_data <= '0;
      wr_mdu     <= 1'b0;
    end else if (alu_valid) begin
      write_en   <= 1'b1;
      write_sel  <= alu_sel;
      write_data <= alu_data;
      wr_mdu     <= 1'b0;
    end else if (pop) begin
      write_en   <= 1'b1;
      write_sel  <= mem[rd_ptr].sel;
      write_data <= mem[rd_ptr].data;
      wr_mdu     <= 1'b1;
    end else if (bypass) begin
      write_en   <= 1'b1;
      write_sel  <= mdu_sel;
      write_data <= mdu_data;
      wr_mdu     <= 1'b1;
    end else begin
      write_en   <= 1'b0;
      wr_mdu     <= 1'b0;
    end
  end

  // Clear after the register file commits the MDU write; a same-edge claim wins.
  always_comb begin
    pending_nxt = pending;
    if (write_en && wr_mdu) pending_nxt[write_sel] = 1'b0;
    if (claim_en)           pending_nxt[claim_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: doc/reg_file_writeback_arbiter.md
# reg_file_writeback_arbiter

Write-back stage directly upstream of the register file write port. Merges single-cycle ALU results and long-latency multiply/divide unit (MDU) results onto the one `write_sel`/`write_data`/`write_en` port the register file exposes. Buffers MDU results in a small FIFO and keeps a pending-register scoreboard that decode uses to stall on unfinished long-latency destinations.

## Interface
- `SEL_WIDTH`, 4: register select width; matches register file select width.
- `DATA_WIDTH`, 32: register data width.
- `FIFO_DEPTH`, 4: MDU result FIFO entries; power of two, ≥2.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `alu_valid`  in  1  ALU result valid this cycle; always accepted.
- `alu_sel`  in  SEL_WIDTH  ALU destination register.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `mdu_valid`  in  1  MDU result offered.
- `mdu_ready`  out  1  MDU result accepted when `mdu_valid && mdu_ready`.
- `mdu_sel`  in  SEL_WIDTH  MDU destination register.
- `mdu_data`  in  DATA_WIDTH  MDU result.
- `claim_en`  in  1  decode issued an MDU op this cycle.
- `claim_sel`  in  SEL_WIDTH  its destination register.
- `pending`  out  2**SEL_WIDTH  bit r set: register r awaits an MDU write.
- `write_sel`  out  SEL_WIDTH  to register file `write_sel`.
- `write_data`  out  DATA_WIDTH  to register file `write_data`.
- `write_en`  out  1  to register file `write_en`.

## Operation
- Output stage: `write_sel`/`write_data`/`write_en` are registers loaded every edge.
- Selection each edge, priority order: (1) `alu_valid` → load ALU result; (2) else FIFO non-empty → pop head and load it; (3) else `write_en`←0, `write_sel`/`write_data` hold.
- ALU never stalls; when the ALU occupies the port, the FIFO does not drain.
- FIFO: circular buffer, read/write pointers wrap modulo `FIFO_DEPTH`, count 0..`FIFO_DEPTH`. Push on `mdu_valid && mdu_ready`. Simultaneous push and pop: count unchanged, both pointers advance.
- `mdu_ready` = count < `FIFO_DEPTH`; combinational from registered count only; never depends on `mdu_valid`.
- Scoreboard: `claim_en` sets `pending[claim_sel]` at the edge. A pending bit clears at the edge after an MDU-sourced write to that register had `write_en` high, i.e. once the register file has committed it. Claim and clear on the same register at the same edge: claim wins, bit stays 1.
- Duplicate claim on an already-pending register: bit stays 1. The first MDU write to it clears it. Decode must not issue such a claim.
- ALU writes never touch `pending`. WAW ordering against pending registers is decode's responsibility.
- Reset: `write_en`=0, `write_sel`=0, `write_data`=0, FIFO empty, pointers 0, `pending`=0, hence `mdu_ready`=1. Reset asserted mid-operation discards all buffered results and claims immediately.

## Timing
- ALU: `alu_valid` in cycle N → `write_en`=1 during N+1.
- MDU, no contention: accepted at edge ending N → popped at edge ending N+1 → `write_en`=1 during N+2. Add 1 cycle per intervening ALU write.
- `pending` clears during the cycle after the MDU write's `write_en` cycle.
- `mdu_ready` drops in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop.

## Configuration
- `REG_WB_FIFO_BYPASS_EN` defined: when `alu_valid`=0, FIFO empty and an MDU handshake occurs, the MDU result loads the output stage directly without entering the FIFO. MDU latency becomes 1 (`write_en` during N+1).
- Undefined: MDU results always pass through the FIFO. Latency 2 as above.
- Priority, scoreboard and reset behaviour are identical in both builds.

## Test plan
- Reset: assert `rst` mid-stream with 3 FIFO entries and `pending`=16'h0006 → all outputs zero, `mdu_ready`=1 asynchronously; after release, no stale write ever appears.
- ALU only: `alu_valid`, sel 5, data 32'hDEADBEEF in cycle N → `write_en`=1, sel 5, data DEADBEEF in N+1; `write_en`=0 in N+2.
- Contention: MDU sel 3 data 7 pushed in N while ALU writes for N..N+2 → ALU writes in N+1..N+3, MDU write in N+4.
- Full FIFO: continuous ALU traffic, push 4 MDU results → `mdu_ready`=0, 5th offer held; stop ALU → writes drain in push order, `mdu_ready`=1 after first pop.
- Scoreboard: claim sel 9 in N; MDU write to r9 with `write_en` high in M → `pending[9]`=1 through M, 0 in M+1. Re-claim r9 at the clearing edge → stays 1.
- Bypass build: idle port, empty FIFO, MDU sel 2 data 1 in N → `write_en` in N+1; non-bypass build → N+2.
